// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - shared strobe-bus constants and monitor state encoding
package clk_pkg;

   localparam int STROBE_W = 6;
   localparam int CE12_B   = 0;
   localparam int CE6_B    = 1;
   localparam int CE3_B    = 2;
   localparam int VS_B     = 3;
   localparam int CE1M5_B  = 4;
   localparam int PAB_B    = 5;

   localparam int PHASE_W = 6;
   localparam logic [PHASE_W-1:0] SYNC_PHASE = 6'd32;

   typedef logic [STROBE_W-1:0] strobe_t;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } mon_state_t;

endpackage

// File: rtl/ce_pattern_predict.sv
// rtl/ce_pattern_predict.sv - expected strobe vector for a given generator phase
module ce_pattern_predict
   import clk_pkg::*;
(
   input  logic [PHASE_W-1:0] phase,
   output strobe_t            pattern
);

   // Bit 4 of the phase does not feed any strobe.
   logic unused_phase4;
   assign unused_phase4 = phase[4];

   always_comb begin
      pattern          = '0;
      pattern[CE12_B]  = phase[0];
      pattern[CE6_B]   = phase[1] & phase[0];
      pattern[CE3_B]   = phase[2] & phase[1] & ~phase[0];
      pattern[VS_B]    = ~phase[2];
      pattern[CE1M5_B] = ~phase[3] & phase[2] & phase[1] & ~phase[0];
      pattern[PAB_B]   = phase[5];
   end

endmodule

// File: rtl/ce_strobe_monitor.sv
// rtl/ce_strobe_monitor.sv - locks a phase counter to the clk24 strobe bus and reports health
module ce_strobe_monitor
   import clk_pkg::*;
#(
   parameter int VERIFY_CYCLES = 64,
   parameter int MAX_MISSES    = 4,
   parameter int ERRW          = 16,
   parameter int HUNT_TIMEOUT  = 200
)
(
   input  logic                clk24,
   input  logic                reset,
   input  logic                ce12,
   input  logic                ce6,
   input  logic                ce3,
   input  logic                video_slice,
   input  logic                ce1m5,
   input  logic                pipe_ab,
   input  logic                clr_err,
   output logic                locked,
   output logic [PHASE_W-1:0]  phase,
   output logic [STROBE_W-1:0] mismatch,
   output logic                sync_err,
   output logic [ERRW-1:0]     err_count,
   output logic                no_strobe
);

   localparam int HW = $clog2(HUNT_TIMEOUT + 1);
   localparam logic [7:0]    VC_LAST   = 8'(VERIFY_CYCLES);
   localparam logic [3:0]    MISS_LAST = 4'(MAX_MISSES);
   localparam logic [HW-1:0] HT_LIM    = HW'(HUNT_TIMEOUT);
   localparam logic [HW-1:0] HT_PRE    = HW'(HUNT_TIMEOUT - 1);

   mon_state_t state, state_next;

   strobe_t         strobes, predicted, diff, mismatch_next;
   logic            pipe_prev, rise, diff_any;
   logic            verify_done, miss_done;
   logic            compare_en, err_inc, locked_next;
   logic [7:0]      verify_ctr;
   logic [3:0]      miss_ctr;
   logic [HW-1:0]   hunt_ctr;

   assign strobes = {pipe_ab, ce1m5, video_slice, ce3, ce6, ce12};

   ce_pattern_predict u_predict (
      .phase   (phase),
      .pattern (predicted)
   );

   assign diff        = strobes ^ predicted;
   assign diff_any    = |diff;
   assign rise        = pipe_ab & ~pipe_prev;
   assign verify_done = (verify_ctr + 8'd1) == VC_LAST;
   assign miss_done   = (miss_ctr + 4'd1) == MISS_LAST;

   always_ff @(posedge clk24 or posedge reset) begin
      if (reset) state <= HUNT;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         HUNT:    if (rise) state_next = VERIFY;
         VERIFY:  if (diff_any) state_next = HUNT;
                  else if (verify_done) state_next = LOCKED;
         LOCKED:  if (diff_any && miss_done) state_next = HUNT;
         default: state_next = HUNT;
      endcase
   end

   always_comb begin
      compare_en    = (state != HUNT);
      err_inc       = compare_en && diff_any;
      locked_next   = (state_next == LOCKED);
      mismatch_next = compare_en ? diff : '0;
   end

   always_ff @(posedge clk24 or posedge reset) begin
      if (reset) begin
         locked     <= 1'b0;
         phase      <= '0;
         mismatch   <= '0;
         sync_err   <= 1'b0;
         err_count  <= '0;
         no_strobe  <= 1'b0;
         pipe_prev  <= 1'b1;
         verify_ctr <= '0;
         miss_ctr   <= '0;
         hunt_ctr   <= '0;
      end else begin
         pipe_prev <= pipe_ab;
         locked    <= locked_next;
         mismatch  <= mismatch_next;
         sync_err  <= err_inc;
         if (clr_err)
            err_count <= '0;
         else if (err_inc && !(&err_count))
            err_count <= err_count + 1'b1;
         if (rise)
            no_strobe <= 1'b0;

         case (state)
            HUNT: begin
               if (rise) begin
                  // The rising edge marks c=SYNC_PHASE, so the next cycle is SYNC_PHASE+1.
                  phase      <= SYNC_PHASE + 6'd1;
                  verify_ctr <= '0;
                  hunt_ctr   <= '0;
               end else begin
                  if (hunt_ctr != HT_LIM)
                     hunt_ctr <= hunt_ctr + 1'b1;
                  if (hunt_ctr >= HT_PRE)
                     no_strobe <= 1'b1;
               end
            end
            VERIFY: begin
               phase    <= phase + 1'b1;
               miss_ctr <= '0;
               if (diff_any)
                  hunt_ctr <= '0;
               else
                  verify_ctr <= verify_ctr + 8'd1;
            end
            LOCKED: begin
               phase <= phase + 1'b1;
               if (diff_any) begin
                  miss_ctr <= miss_ctr + 4'd1;
                  if (miss_done)
                     hunt_ctr <= '0;
               end else begin
                  miss_ctr <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ce_strobe_monitor.sv
// tb/tb_ce_strobe_monitor.sv - self-checking bench for ce_strobe_monitor
module tb_ce_strobe_monitor;

   localparam int VERIFY_CYCLES = 64;
   localparam int MAX_MISSES    = 4;

   logic clk24 = 1'b0;
   logic reset;
   logic ce12, ce6, ce3, video_slice, ce1m5, pipe_ab, clr_err;

   logic        locked, sync_err, no_strobe;
   logic [5:0]  phase, mismatch;
   logic [15:0] err_count;

   logic        locked4, sync_err4, no_strobe4;
   logic [5:0]  phase4, mismatch4;
   logic [3:0]  err_count4;

   logic [5:0]  ref_phase, ref_pat;

   always #5 clk24 = ~clk24;

   ce_strobe_monitor dut (
      .clk24(clk24), .reset(reset), .ce12(ce12), .ce6(ce6), .ce3(ce3),
      .video_slice(video_slice), .ce1m5(ce1m5), .pipe_ab(pipe_ab), .clr_err(clr_err),
      .locked(locked), .phase(phase), .mismatch(mismatch), .sync_err(sync_err),
      .err_count(err_count), .no_strobe(no_strobe)
   );

   ce_strobe_monitor #(.ERRW(4)) dut4 (
      .clk24(clk24), .reset(reset), .ce12(ce12), .ce6(ce6), .ce3(ce3),
      .video_slice(video_slice), .ce1m5(ce1m5), .pipe_ab(pipe_ab), .clr_err(clr_err),
      .locked(locked4), .phase(phase4), .mismatch(mismatch4), .sync_err(sync_err4),
      .err_count(err_count4), .no_strobe(no_strobe4)
   );

   ce_pattern_predict u_ref (.phase(ref_phase), .pattern(ref_pat));

   typedef struct {
      logic [5:0] ph;
      logic [5:0] pat;
   } pred_vec_t;

   typedef struct {
      logic        locked;
      logic [5:0]  phase;
      logic [5:0]  mism;
      logic        serr;
      logic [15:0] err;
      logic [3:0]  err4;
   } exp_t;

   exp_t      sb[$];
   pred_vec_t tbl[10];
   int        n_vec = 0;
   int        n_err = 0;
   int        gc;

   int   m_state, m_phase, m_vcnt, m_miss, m_err, m_err4;
   logic m_prev;

   function automatic logic [5:0] gen(input int c);
      logic [5:0] b;
      b = c[5:0];
      return {b[5], ~b[3] & b[2] & b[1] & ~b[0], ~b[2], b[2] & b[1] & ~b[0], b[1] & b[0], b[0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, want, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_phase = 0; m_vcnt = 0; m_miss = 0;
      m_err = 0; m_err4 = 0; m_prev = 1'b1;
   endtask

   task automatic model_step(input logic [5:0] v, input logic clr, output exp_t e);
      logic [5:0] mm;
      bit rise, inc;
      rise = v[5] && !m_prev;
      m_prev = v[5];
      inc = 0;
      mm = '0;
      if (m_state == 0) begin
         if (rise) begin m_phase = 33; m_vcnt = 0; m_state = 1; end
      end else begin
         mm = v ^ gen(m_phase);
         m_phase = (m_phase + 1) % 64;
         if (mm != 0) begin
            inc = 1;
            if (m_state == 1) m_state = 0;
            else begin
               m_miss++;
               if (m_miss >= MAX_MISSES) m_state = 0;
            end
         end else if (m_state == 1) begin
            m_vcnt++;
            if (m_vcnt == VERIFY_CYCLES) begin m_state = 2; m_miss = 0; end
         end else begin
            m_miss = 0;
         end
      end
      if (clr) begin m_err = 0; m_err4 = 0; end
      else if (inc) begin
         if (m_err < 65535) m_err++;
         if (m_err4 < 15) m_err4++;
      end
      e.locked = (m_state == 2);
      e.phase  = m_phase[5:0];
      e.mism   = mm;
      e.serr   = inc;
      e.err    = m_err[15:0];
      e.err4   = m_err4[3:0];
   endtask

   // Called at posedge+1: drive one cycle, let the DUT consume it, compare after the edge.
   task automatic step(input logic [5:0] v, input logic clr);
      exp_t e, got;
      {pipe_ab, ce1m5, video_slice, ce3, ce6, ce12} = v;
      clr_err = clr;
      model_step(v, clr, e);
      sb.push_back(e);
      @(posedge clk24);
      #1;
      got = sb.pop_front();
      chk("locked", locked, got.locked);
      chk("phase", phase, got.phase);
      chk("mismatch", mismatch, got.mism);
      chk("sync_err", sync_err, got.serr);
      chk("err_count", err_count, got.err);
      chk("err_count_w4", err_count4, got.err4);
   endtask

   task automatic run_gen(input int n);
      for (int i = 0; i < n; i++) begin step(gen(gc), 1'b0); gc++; end
   endtask

   task automatic run_to(input int c);
      for (int i = 0; i < 64 && (gc % 64) != c; i++) begin step(gen(gc), 1'b0); gc++; end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_locked"}, locked, 0);
      chk({tag, "_phase"}, phase, 0);
      chk({tag, "_mismatch"}, mismatch, 0);
      chk({tag, "_sync_err"}, sync_err, 0);
      chk({tag, "_err_count"}, err_count, 0);
      chk({tag, "_no_strobe"}, no_strobe, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      clr_err = 1'b0;
      {pipe_ab, ce1m5, video_slice, ce3, ce6, ce12} = '0;
      model_reset();

      tbl[0] = '{6'd0,  6'b001000};
      tbl[1] = '{6'd1,  6'b001001};
      tbl[2] = '{6'd3,  6'b001011};
      tbl[3] = '{6'd4,  6'b000000};
      tbl[4] = '{6'd6,  6'b010100};
      tbl[5] = '{6'd14, 6'b000100};
      tbl[6] = '{6'd32, 6'b101000};
      tbl[7] = '{6'd33, 6'b101001};
      tbl[8] = '{6'd38, 6'b110100};
      tbl[9] = '{6'd63, 6'b100011};
      for (int i = 0; i < 10; i++) begin
         ref_phase = tbl[i].ph;
         #1;
         chk("predict_table", ref_pat, tbl[i].pat);
      end
      for (int p = 0; p < 64; p++) begin
         ref_phase = 6'(p);
         #1;
         chk("predict_sweep", ref_pat, gen(p));
      end

      repeat (3) @(posedge clk24);
      #1;
      check_reset_outputs("reset");
      reset = 1'b0;

      // Clean generator after an idle startup hold.
      for (int i = 0; i < 5; i++) step(6'b000000, 1'b0);
      gc = 0;
      for (int n = 0; n < 1100; n++) begin
         step(gen(gc), 1'b0);
         gc++;
         if (n == 95) chk("lock_early", locked, 0);
         if (n == 96) chk("lock_after_64", locked, 1);
      end
      chk("clean_phase_track", phase, gc % 64);
      chk("clean_err_zero", err_count, 0);
      chk("clean_no_strobe", no_strobe, 0);

      // Single ce3 glitch at c=10.
      run_to(10);
      step(gen(gc) | 6'b000100, 1'b0);
      gc++;
      chk("glitch_mismatch", mismatch, 6'b000100);
      chk("glitch_sync_err", sync_err, 1);
      chk("glitch_err_count", err_count, 1);
      chk("glitch_locked", locked, 1);
      run_gen(1);
      chk("glitch_pulse_end", sync_err, 0);

      // Four-cycle ce12 burst starting at c=40, then relock.
      step(gen(gc), 1'b1);
      gc++;
      chk("clr_err", err_count, 0);
      run_to(40);
      for (int k = 0; k < 4; k++) begin
         step(gen(gc) ^ 6'b000001, 1'b0);
         gc++;
         if (k == 2) chk("burst_still_locked", locked, 1);
      end
      chk("burst_err_count", err_count, 4);
      chk("burst_unlocked", locked, 0);
      run_to(32);
      run_gen(1);
      for (int k = 1; k <= 64; k++) begin
         run_gen(1);
         if (k == 63) chk("burst_relock_early", locked, 0);
         if (k == 64) chk("burst_relock", locked, 1);
      end

      // Phase slip: the generator repeats one cycle.
      run_to(20);
      step(gen(gc), 1'b0);
      for (int k = 0; k < 4; k++) begin
         step(gen(gc), 1'b0);
         gc++;
         if (k == 2) chk("slip_still_locked", locked, 1);
      end
      chk("slip_unlocked", locked, 0);
      for (int k = 0; k < 200 && !locked; k++) run_gen(1);
      chk("slip_relock", locked, 1);
      chk("slip_phase", phase, gc % 64);

      // pipe_ab stuck high from reset.
      reset = 1'b1;
      model_reset();
      @(posedge clk24);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 250; k++) begin
         step(6'b100000, 1'b0);
         if (k == 189) chk("stuck_no_strobe_early", no_strobe, 0);
         if (k == 209) chk("stuck_no_strobe", no_strobe, 1);
      end
      gc = 0;
      run_gen(32);
      chk("stuck_hold", no_strobe, 1);
      run_gen(1);
      chk("stuck_release", no_strobe, 0);

      // Saturation of a 4-bit counter and clear-wins-over-increment.
      reset = 1'b1;
      model_reset();
      @(posedge clk24);
      #1;
      reset = 1'b0;
      step(6'b000000, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(gen(32), 1'b0);
         step(6'b000000, 1'b0);
      end
      chk("sat_err4", err_count4, 15);
      chk("sat_err16", err_count, 20);
      step(gen(32), 1'b0);
      step(6'b000000, 1'b1);
      chk("clr_wins_sync_err", sync_err, 1);
      chk("clr_wins_err", err_count, 0);
      chk("clr_wins_err4", err_count4, 0);

      // Reset in the middle of VERIFY, with strobes wiggling during reset.
      step(gen(32), 1'b0);
      step(6'b000000, 1'b0);
      step(gen(32), 1'b0);
      for (int c = 33; c < 37; c++) step(gen(c), 1'b0);
      chk("pre_reset_phase", phase, 37);
      chk("pre_reset_err", err_count, 1);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      for (int k = 0; k < 5; k++) begin
         @(posedge clk24);
         #1;
         {pipe_ab, ce1m5, video_slice, ce3, ce6, ce12} = 6'($urandom_range(0, 63));
         clr_err = 1'b0;
      end
      @(posedge clk24);
      #1;
      check_reset_outputs("held_reset");
      model_reset();
      reset = 1'b0;
      step(6'b000000, 1'b0);
      step(6'b000000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
